// File: rtl/zports_pkg.sv
// Shared constants and types for the zports port-register stage.
package zports_pkg;

   localparam logic [1:0] REG_SL811 = 2'd0;
   localparam logic [1:0] REG_CFG   = 2'd1;
   localparam logic [1:0] REG_IEN   = 2'd2;
   localparam logic [1:0] REG_STAT  = 2'd3;

   localparam int CFG_WIN_LSB    = 0;
   localparam int CFG_ENA_BIT    = 4;
   localparam int CFG_SRST_BIT   = 7;

   localparam int STAT_W5300_BIT = 0;
   localparam int STAT_SL811_BIT = 1;
   localparam int STAT_ZINT_BIT  = 6;
   localparam int STAT_BUSY_BIT  = 7;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } rst_state_t;

endpackage

// File: rtl/zports_sync.sv
// Multi-stage synchroniser for one asynchronous input; resets to 1 so idle
// active-low strobes and interrupts look inactive out of reset.
module zports_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic fclk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] ff;

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) ff <= '1;
      else        ff <= {ff[SYNC_STAGES-2:0], d};
   end

   assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/zports.sv
// Port registers behind the ZX-bus decoder: CFG/IEN/STAT, chip reset generator
// and interrupt merge. Define ZPORTS_INT_LATCH_EN for sticky STAT[1:0] pending bits.
//
// state   | meaning
// ST_HOLD | chip resets asserted, counting RST_CYCLES fclk
// ST_IDLE | chips out of reset, normal operation
module zports
   import zports_pkg::*;
#(
   parameter int RST_CYCLES  = 1000,
   parameter int SYNC_STAGES = 2
) (
   input  logic       fclk,
   input  logic       rst_n,
   input  logic       ports_wrena,
   input  logic       ports_wrstb_n,
   input  logic [1:0] ports_addr,
   input  logic [7:0] ports_wrdata,
   output logic [7:0] ports_rddata,
   output logic [1:0] rommap_win,
   output logic       rommap_ena,
   input  logic       w5300_int_n,
   input  logic       sl811_int_n,
   output logic       w5300_rst_n,
   output logic       sl811_rst_n,
   output logic       zint_n
);

   localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(RST_CYCLES - 1);

   logic       wr_s, wr_s_d;
   logic [1:0] int_s;
   logic       hold_ena;
   logic [1:0] hold_addr;
   logic [7:0] hold_data;
   logic       commit, cfg_wr, soft_rst;
   logic [1:0] ien;
   logic [1:0] pending;
   rst_state_t state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic       busy, chip_rst_n;

   zports_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_wr (
      .fclk(fclk), .rst_n(rst_n), .d(ports_wrstb_n), .q(wr_s));
   zports_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_w5300 (
      .fclk(fclk), .rst_n(rst_n), .d(w5300_int_n), .q(int_s[STAT_W5300_BIT]));
   zports_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sl811 (
      .fclk(fclk), .rst_n(rst_n), .d(sl811_int_n), .q(int_s[STAT_SL811_BIT]));

   // Keep sampling the bus while the strobe is low; the last sample wins.
   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         wr_s_d    <= 1'b1;
         hold_ena  <= 1'b0;
         hold_addr <= 2'b00;
         hold_data <= 8'h00;
      end else begin
         wr_s_d <= wr_s;
         if (!wr_s) begin
            hold_ena  <= ports_wrena;
            hold_addr <= ports_addr;
            hold_data <= ports_wrdata;
         end
      end
   end

   assign commit   = wr_s & ~wr_s_d & hold_ena;
   assign cfg_wr   = commit & (hold_addr == REG_CFG);
   assign soft_rst = cfg_wr & hold_data[CFG_SRST_BIT];

   wire unused_hold_bits = ^{hold_data[6:5], hold_data[3:2]};

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         rommap_win <= 2'b00;
         rommap_ena <= 1'b0;
         ien        <= 2'b00;
      end else begin
         if (cfg_wr) begin
            rommap_win <= hold_data[CFG_WIN_LSB +: 2];
            rommap_ena <= hold_data[CFG_ENA_BIT];
         end
         if (commit && hold_addr == REG_IEN)
            ien <= hold_data[1:0];
      end
   end

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) state <= ST_HOLD;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (soft_rst)
         state_nxt = ST_HOLD;
      else if (state == ST_HOLD && cnt == CNT_TC)
         state_nxt = ST_IDLE;
   end

   always_comb begin
      busy       = (state == ST_HOLD);
      chip_rst_n = (state == ST_IDLE);
   end

   // A soft reset during HOLD restarts the count from zero.
   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (soft_rst || state == ST_IDLE)
         cnt <= '0;
      else if (cnt != CNT_TC)
         cnt <= cnt + CNT_W'(1);
   end

   assign w5300_rst_n = chip_rst_n;
   assign sl811_rst_n = chip_rst_n;

`ifdef ZPORTS_INT_LATCH_EN
   logic [1:0] int_s_d, int_fall, int_lat, stat_clr;

   assign int_fall = int_s_d & ~int_s;
   assign stat_clr = (commit && hold_addr == REG_STAT) ? hold_data[1:0] : 2'b00;

   // A fresh edge beats a clear landing in the same cycle.
   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         int_s_d <= 2'b11;
         int_lat <= 2'b00;
      end else begin
         int_s_d <= int_s;
         if (busy || state_nxt == ST_HOLD)
            int_lat <= 2'b00;
         else
            int_lat <= (int_lat & ~stat_clr) | int_fall;
      end
   end

   assign pending = busy ? 2'b00 : (int_lat | int_fall);
`else
   assign pending = busy ? 2'b00 : ~int_s;
`endif

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) zint_n <= 1'b1;
      else        zint_n <= ~|(pending & ien);
   end

   always_comb begin
      ports_rddata = 8'h00;
      case (ports_addr)
         REG_SL811: ports_rddata = 8'hFF;
         REG_CFG: begin
            ports_rddata[CFG_WIN_LSB +: 2] = rommap_win;
            ports_rddata[CFG_ENA_BIT]      = rommap_ena;
         end
         REG_IEN:   ports_rddata[1:0] = ien;
         REG_STAT: begin
            ports_rddata[STAT_W5300_BIT] = pending[STAT_W5300_BIT];
            ports_rddata[STAT_SL811_BIT] = pending[STAT_SL811_BIT];
            ports_rddata[STAT_ZINT_BIT]  = ~zint_n;
            ports_rddata[STAT_BUSY_BIT]  = busy;
         end
         default: ports_rddata = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_zports.sv
// Self-checking bench for zports: reset timing, register writes, soft reset, interrupts.
module tb_zports;

   localparam int SYNC = 2;
   localparam int RSTC = 1000;

   logic       fclk;
   logic       rst_n;
   logic       ports_wrena;
   logic       ports_wrstb_n;
   logic [1:0] ports_addr;
   logic [7:0] ports_wrdata;
   logic [7:0] ports_rddata;
   logic [1:0] rommap_win;
   logic       rommap_ena;
   logic       w5300_int_n;
   logic       sl811_int_n;
   logic       w5300_rst_n;
   logic       sl811_rst_n;
   logic       zint_n;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [7:0] val;
      string      tag;
   } sb_t;
   sb_t exp_q[$];

   zports #(.RST_CYCLES(RSTC), .SYNC_STAGES(SYNC)) dut (
      .fclk(fclk), .rst_n(rst_n),
      .ports_wrena(ports_wrena), .ports_wrstb_n(ports_wrstb_n),
      .ports_addr(ports_addr), .ports_wrdata(ports_wrdata),
      .ports_rddata(ports_rddata),
      .rommap_win(rommap_win), .rommap_ena(rommap_ena),
      .w5300_int_n(w5300_int_n), .sl811_int_n(sl811_int_n),
      .w5300_rst_n(w5300_rst_n), .sl811_rst_n(sl811_rst_n),
      .zint_n(zint_n));

   initial fclk = 1'b0;
   always #5 fclk = ~fclk;

   task automatic step(input int n);
      repeat (n) @(posedge fclk);
      #1;
   endtask

   task automatic read_check(input logic [1:0] addr, input logic [7:0] exp, input string tag);
      sb_t e;
      ports_addr = addr;
      exp_q.push_back('{val: exp, tag: tag});
      @(negedge fclk);
      e = exp_q.pop_front();
      checks++;
      if (ports_rddata !== e.val) begin
         failures++;
         $display("FAIL %s: rddata=%h expected=%h", e.tag, ports_rddata, e.val);
      end
   endtask

   // Strobe low for 'low' cycles, then wait until just after the commit edge.
   task automatic bus_write(input logic [1:0] addr, input logic [7:0] data,
                            input logic ena, input int low, input bit pull_sl811);
      step(1);
      ports_addr    = addr;
      ports_wrdata  = data;
      ports_wrena   = ena;
      ports_wrstb_n = 1'b0;
      step(low);
      ports_wrstb_n = 1'b1;
      if (pull_sl811) sl811_int_n = 1'b0;
      step(SYNC + 1);
      ports_wrena = 1'b0;
   endtask

   task automatic test_reset();
      int n;
      logic [7:0] stat_mid;
      rst_n = 1'b0;
      step(3);
      checks++;
      if (w5300_rst_n !== 1'b0 || sl811_rst_n !== 1'b0 || zint_n !== 1'b1) begin
         failures++;
         $display("FAIL reset_outputs: w5300_rst_n=%b sl811_rst_n=%b zint_n=%b expected 0 0 1",
                  w5300_rst_n, sl811_rst_n, zint_n);
      end
      read_check(2'd3, 8'h80, "reset_stat");
      read_check(2'd1, 8'h00, "reset_cfg");
      step(1);
      rst_n = 1'b1;
      ports_addr = 2'd3;
      n = 0;
      stat_mid = 8'h00;
      do begin
         step(1);
         n++;
         if (n == 500) stat_mid = ports_rddata;
      end while (w5300_rst_n === 1'b0 && n < 2 * RSTC);
      checks++;
      if (n != RSTC || sl811_rst_n !== 1'b1) begin
         failures++;
         $display("FAIL reset_length: low_cycles=%0d sl811_rst_n=%b expected %0d 1", n, sl811_rst_n, RSTC);
      end
      checks++;
      if (stat_mid !== 8'h80) begin
         failures++;
         $display("FAIL hold_stat: stat=%h expected=80", stat_mid);
      end
      read_check(2'd3, 8'h00, "idle_stat");
      checks++;
      if (rommap_ena !== 1'b0) begin
         failures++;
         $display("FAIL reset_ena: rommap_ena=%b expected 0", rommap_ena);
      end
   endtask

   task automatic test_cfg_write();
      step(1);
      ports_addr    = 2'd1;
      ports_wrdata  = 8'h13;
      ports_wrena   = 1'b1;
      ports_wrstb_n = 1'b0;
      step(3);
      ports_wrstb_n = 1'b1;
      step(SYNC);
      checks++;
      if (rommap_ena !== 1'b0) begin
         failures++;
         $display("FAIL cfg_early: rommap_ena=%b expected 0", rommap_ena);
      end
      step(1);
      checks++;
      if (rommap_win !== 2'b11 || rommap_ena !== 1'b1) begin
         failures++;
         $display("FAIL cfg_commit: win=%b ena=%b expected 11 1", rommap_win, rommap_ena);
      end
      ports_wrena = 1'b0;
      read_check(2'd1, 8'h13, "cfg_read");
   endtask

   task automatic test_wrena0();
      bus_write(2'd1, 8'h00, 1'b0, 3, 1'b0);
      checks++;
      if (rommap_win !== 2'b11 || rommap_ena !== 1'b1) begin
         failures++;
         $display("FAIL wrena0_cfg: win=%b ena=%b expected 11 1", rommap_win, rommap_ena);
      end
      read_check(2'd1, 8'h13, "wrena0_cfg_read");
      bus_write(2'd2, 8'h03, 1'b0, 3, 1'b0);
      read_check(2'd2, 8'h00, "wrena0_ien_read");
   endtask

   task automatic test_reg_reads();
      bus_write(2'd2, 8'hFF, 1'b1, 3, 1'b0);
      read_check(2'd2, 8'h03, "ien_read");
      read_check(2'd0, 8'hFF, "sl811_read_a");
      bus_write(2'd1, 8'h6C, 1'b1, 2, 1'b0);
      read_check(2'd1, 8'h00, "cfg_unused_bits");
      bus_write(2'd0, 8'h00, 1'b1, 3, 1'b0);
      read_check(2'd0, 8'hFF, "sl811_read_b");
      bus_write(2'd1, 8'h13, 1'b1, 3, 1'b0);
      bus_write(2'd2, 8'h00, 1'b1, 3, 1'b0);
      read_check(2'd1, 8'h13, "cfg_restore");
   endtask

   task automatic test_irq();
      bus_write(2'd2, 8'h01, 1'b1, 3, 1'b0);
      ports_addr = 2'd3;
      step(2);
      w5300_int_n = 1'b0;
      step(SYNC);
      checks++;
      if (zint_n !== 1'b1) begin
         failures++;
         $display("FAIL zint_early: zint_n=%b expected 1", zint_n);
      end
      step(1);
      checks++;
      if (zint_n !== 1'b0) begin
         failures++;
         $display("FAIL zint_assert: zint_n=%b expected 0", zint_n);
      end
      read_check(2'd3, 8'h41, "irq_stat");
      w5300_int_n = 1'b1;
      bus_write(2'd2, 8'h00, 1'b1, 3, 1'b0);
      step(2);
`ifdef ZPORTS_INT_LATCH_EN
      read_check(2'd3, 8'h01, "irq_release_stat");
`else
      read_check(2'd3, 8'h00, "irq_release_stat");
`endif
      step(1);
      w5300_int_n = 1'b0;
      step(5);
      checks++;
      if (zint_n !== 1'b1) begin
         failures++;
         $display("FAIL zint_masked: zint_n=%b expected 1", zint_n);
      end
      read_check(2'd3, 8'h01, "masked_stat");
`ifdef ZPORTS_INT_LATCH_EN
      bus_write(2'd3, 8'h01, 1'b1, 3, 1'b0);
      read_check(2'd3, 8'h00, "stat_clear_w5300");
`else
      bus_write(2'd3, 8'h03, 1'b1, 3, 1'b0);
      read_check(2'd3, 8'h01, "stat_write_ignored");
`endif
      step(1);
      w5300_int_n = 1'b1;
      step(4);
      read_check(2'd3, 8'h00, "irq_idle_stat");
   endtask

`ifdef ZPORTS_INT_LATCH_EN
   task automatic test_latch();
      ports_addr = 2'd3;
      step(1);
      sl811_int_n = 1'b0;
      step(4);
      sl811_int_n = 1'b1;
      step(4);
      read_check(2'd3, 8'h02, "latch_sticky");
      bus_write(2'd3, 8'h02, 1'b1, 3, 1'b0);
      read_check(2'd3, 8'h00, "latch_clear");
      step(1);
      bus_write(2'd3, 8'h02, 1'b1, 3, 1'b1);
      read_check(2'd3, 8'h02, "latch_set_wins");
      step(1);
      sl811_int_n = 1'b1;
      bus_write(2'd3, 8'h02, 1'b1, 3, 1'b0);
      read_check(2'd3, 8'h00, "latch_final_clear");
   endtask
`endif

   task automatic test_soft_reset();
      int n;
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(494);
      bus_write(2'd1, 8'h92, 1'b1, 2, 1'b0);
      checks++;
      if (w5300_rst_n !== 1'b0 || rommap_win !== 2'b10 || rommap_ena !== 1'b1) begin
         failures++;
         $display("FAIL soft_rst_commit: rst_n=%b win=%b ena=%b expected 0 10 1",
                  w5300_rst_n, rommap_win, rommap_ena);
      end
      n = 0;
      do begin
         step(1);
         n++;
      end while (w5300_rst_n === 1'b0 && n < 3 * RSTC);
      checks++;
      if (n != RSTC || sl811_rst_n !== 1'b1) begin
         failures++;
         $display("FAIL soft_rst_length: low_cycles=%0d sl811_rst_n=%b expected %0d 1", n, sl811_rst_n, RSTC);
      end
      read_check(2'd1, 8'h12, "soft_rst_cfg");
      read_check(2'd3, 8'h00, "soft_rst_stat");
   endtask

   initial begin
      rst_n         = 1'b0;
      ports_wrena   = 1'b0;
      ports_wrstb_n = 1'b1;
      ports_addr    = 2'd0;
      ports_wrdata  = 8'h00;
      w5300_int_n   = 1'b1;
      sl811_int_n   = 1'b1;
      test_reset();
      test_cfg_write();
      test_wrena0();
      test_reg_reads();
      test_irq();
`ifdef ZPORTS_INT_LATCH_EN
      test_latch();
`endif
      test_soft_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/zports.md
Name: zports

Overview:
- Port-register stage directly downstream of the ZX-bus decoder.
- Consumes the decoder's write bundle (ports_wrena, ports_wrstb_n, ports_addr, ports_wrdata) and returns ports_rddata.
- Drives rommap_win/rommap_ena back to the decoder, and generates chip resets for the W5300 and SL811.
- Synchronises their interrupt lines into a single ZX interrupt request.
- Runs on fclk; all bus-side strobes are treated as asynchronous.

Parameters:
- RST_CYCLES, 1000: fclk cycles that w5300_rst_n/sl811_rst_n stay low after reset or a soft-reset write.
- SYNC_STAGES, 2: flip-flop depth of every asynchronous-input synchroniser (minimum 2).

Ports:
- fclk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ports_wrena  input  1  decoder: address matches a writable register window
- ports_wrstb_n  input  1  decoder: IORQ|WR, low during a write cycle (async)
- ports_addr  input  2  register index (za[9:8])
- ports_wrdata  input  8  write data (zd)
- ports_rddata  output  8  read data to decoder
- rommap_win  output  2  16K window index for W5300 mapping
- rommap_ena  output  1  W5300 memory mapping enable
- w5300_int_n  input  1  W5300 interrupt, active low (async)
- sl811_int_n  input  1  SL811 interrupt, active low (async)
- w5300_rst_n  output  1  W5300 reset
- sl811_rst_n  output  1  SL811 reset
- zint_n  output  1  combined interrupt request to ZX bus, active low

Behaviour:
Register map:
- 00: owned by SL811. No write effect; reads return 8'hFF.
- 01 CFG: [1:0] rommap_win, [4] rommap_ena, [7] soft reset. Bit 7 is self-clearing and always reads 0. Other bits read 0.
- 10 IEN: [0] W5300 interrupt enable, [1] SL811 interrupt enable. Other bits read 0.
- 11 STAT (read):
  - [0] W5300 int pending, [1] SL811 int pending.
  - [6] zint active.
  - [7] reset busy.
  - Other bits read 0.

Write path:
- ports_wrstb_n passes through a SYNC_STAGES synchroniser to give the synced strobe wr_s.
- While wr_s=0, ports_wrena/ports_addr/ports_wrdata are captured every fclk into a holding register (the last capture wins).
- On the 0->1 edge of wr_s, if the held wrena=1, the held data commits to the held address. Commit occurs exactly one fclk after the edge is seen.
- A write with wrena=0 commits nothing.
- A strobe glitch shorter than one fclk may be lost; this is acceptable.

Read path:
- ports_rddata is a combinational mux on ports_addr over the current register values; there is no latency.

Reset generator (FSM IDLE/HOLD):
- Async reset enters HOLD with counter=0 and both chip reset outputs low.
- In HOLD the counter increments each fclk. At RST_CYCLES-1 the FSM moves to IDLE and both chip resets go high.
- A commit to CFG with bit7=1 enters HOLD with counter=0. This applies even when the FSM is already in HOLD, which restarts the count.
- The other CFG bits from the same write are committed normally.
- STAT[7]=1 while in HOLD.

Interrupts:
- Both *_int_n inputs are synchronised over SYNC_STAGES.
- pending = synced inverted level (see Optional Feature).
- zint_n = ~|(pending & IEN[1:0]), registered, so it lags by one fclk.
- During HOLD, pending is forced to 0; chip interrupt outputs are undefined while the chips are in reset.

Reset values:
- rommap_win=0, rommap_ena=0, IEN=0.
- zint_n=1.
- w5300_rst_n=0, sl811_rst_n=0.
- Synchronisers all 1; holding register 0.
- ports_rddata follows the registers.

Optional Feature:
Macro ZPORTS_INT_LATCH_EN.
- When defined: STAT[1:0] are sticky.
  - Set on the synced falling edge of the respective int_n.
  - Cleared by writing 1 to the same bit of STAT (addr 11).
  - If set and clear occur in the same fclk, set wins.
  - Cleared by HOLD entry.
- When undefined: STAT[1:0] are the live synced levels, and writes to addr 11 are ignored.

Decomposition:
- Package zports_pkg holds:
  - register index constants REG_SL811=2'd0, REG_CFG=2'd1, REG_IEN=2'd2, REG_STAT=2'd3;
  - CFG/STAT bit-position constants;
  - the reset FSM state typedef (IDLE, HOLD).
- One natural sub-module, zports_sync: a parameterised SYNC_STAGES flip-flop synchroniser with reset value 1. It is instantiated for wrstb_n and for each int_n.

Test Plan:
- Release rst_n -> both chip resets low for exactly 1000 fclk then high; STAT reads 8'h80 during HOLD and 8'h00 after; rommap_ena=0.
- Write 8'h13 to addr 01 (wrena=1, strobe low for 3 fclk) -> one fclk after the synced rising edge, rommap_win=2'b11 and rommap_ena=1; a read of addr 01 returns 8'h13.
- Same write with wrena=0 -> registers unchanged. Write 8'h80 to 01 mid-HOLD at count 500 -> count restarts and the resets stay low for a further 1000 fclk.
- IEN=8'h01, pull w5300_int_n low -> zint_n low after SYNC_STAGES+1 fclk and STAT=8'h41; with IEN=0 the same stimulus leaves zint_n=1.
- Read addr 00 -> 8'hFF regardless of register contents.
- ZPORTS_INT_LATCH_EN: pulse sl811_int_n low for 4 fclk -> STAT[1] stays 1 after release. Write 8'h02 to 11 -> STAT[1]=0. Clear coincident with a new edge -> STAT[1] remains 1.
